// File: rtl/branch_resolution_queue_pkg.sv
// Shared defaults and counter helpers for the branch resolution queue.
// Counter width is used by the optional BRQ_MISPREDICT_STATS_EN counters.
package branch_resolution_queue_pkg;

    localparam int BRQ_ADDR_W = 1;
    localparam int BRQ_DEPTH  = 4;
    localparam int BRQ_CNT_W  = 16;

    function automatic logic [BRQ_CNT_W-1:0] brq_sat_inc(
        input logic [BRQ_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/branch_resolution_queue_if.sv
// Issue / resolve / predictor-update bundle of the branch resolution queue.
// slave is the queue side, master is the pipeline/predictor side.
interface branch_resolution_queue_if
    import branch_resolution_queue_pkg::*;
#(
    parameter int address_width = BRQ_ADDR_W
);
    logic                     pred_valid;
    logic [address_width-1:0] pred_address;
    logic                     pred_taken;
    logic                     pred_ready;
    logic                     res_valid;
    logic                     res_taken;
    logic                     upd_cs;
    logic                     upd_enable;
    logic [address_width-1:0] upd_address;
    logic                     upd_result;
    logic                     mispredict;
    logic                     res_error;

    modport slave (
        input  pred_valid, pred_address, pred_taken,
        input  res_valid, res_taken,
        output pred_ready,
        output upd_cs, upd_enable, upd_address, upd_result,
        output mispredict, res_error
    );

    modport master (
        output pred_valid, pred_address, pred_taken,
        output res_valid, res_taken,
        input  pred_ready,
        input  upd_cs, upd_enable, upd_address, upd_result,
        input  mispredict, res_error
    );
endinterface

// File: rtl/brq_fifo.sv
// Circular buffer of {address, predicted bit} with wrap pointers and count.
// Flush empties the queue by snapping head onto tail.
module brq_fifo #(
    parameter int AW    = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [AW-1:0]            i_push_addr,
    input  logic                     i_push_pred,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [AW-1:0]            o_head_addr,
    output logic                     o_head_pred,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] r_addr_mem [DEPTH];
    logic          r_pred_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr_mem[r_tail] <= i_push_addr;
            r_pred_mem[r_tail] <= i_push_pred;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + 1'b1;
            if (i_pop)  r_head <= r_head + 1'b1;
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_addr = r_addr_mem[r_head];
    assign o_head_pred = r_pred_mem[r_head];
    assign o_count     = r_count;
    assign o_full      = (r_count == (PW+1)'(DEPTH));

endmodule

// File: rtl/branch_resolution_queue.sv
// Tracks in-flight predicted branches, trains the predictor on resolution.
// BRQ_MISPREDICT_STATS_EN adds saturating mispredict/resolve counters.
module branch_resolution_queue
    import branch_resolution_queue_pkg::*;
#(
    parameter int address_width = BRQ_ADDR_W,
    parameter int depth         = BRQ_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    branch_resolution_queue_if.slave      bus
`ifdef BRQ_MISPREDICT_STATS_EN
    ,
    output logic [BRQ_CNT_W-1:0]          mispredict_count,
    output logic [BRQ_CNT_W-1:0]          resolve_count
`endif
);
    localparam int PW = $clog2(depth);

    logic                     w_pop;
    logic                     w_mis;
    logic                     w_push;
    logic                     w_full;
    logic [PW:0]              w_count;
    logic [address_width-1:0] w_head_addr;
    logic                     w_head_pred;

    logic                     r_upd;
    logic [address_width-1:0] r_upd_address;
    logic                     r_upd_result;
    logic                     r_mispredict;
    logic                     r_res_error;

    // A mispredict flushes the queue, so a same-cycle issue is discarded.
    assign w_pop  = bus.res_valid && (w_count != '0);
    assign w_mis  = w_pop && (w_head_pred != bus.res_taken);
    assign w_push = bus.pred_valid && !w_full && !w_mis;

    brq_fifo #(
        .AW    (address_width),
        .DEPTH (depth)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_addr (bus.pred_address),
        .i_push_pred (bus.pred_taken),
        .i_pop       (w_pop),
        .i_flush     (w_mis),
        .o_head_addr (w_head_addr),
        .o_head_pred (w_head_pred),
        .o_count     (w_count),
        .o_full      (w_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd         <= 1'b0;
            r_upd_address <= '0;
            r_upd_result  <= 1'b0;
            r_mispredict  <= 1'b0;
            r_res_error   <= 1'b0;
        end else begin
            r_upd        <= w_pop;
            r_mispredict <= w_mis;
            r_res_error  <= bus.res_valid && (w_count == '0);
            if (w_pop) begin
                r_upd_address <= w_head_addr;
                r_upd_result  <= bus.res_taken;
            end
        end
    end

    assign bus.pred_ready  = !w_full;
    assign bus.upd_cs      = r_upd;
    assign bus.upd_enable  = r_upd;
    assign bus.upd_address = r_upd_address;
    assign bus.upd_result  = r_upd_result;
    assign bus.mispredict  = r_mispredict;
    assign bus.res_error   = r_res_error;

`ifdef BRQ_MISPREDICT_STATS_EN
    logic [BRQ_CNT_W-1:0] r_mis_cnt;
    logic [BRQ_CNT_W-1:0] r_res_cnt;

    // Counters step on the same edge that raises the matching pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mis_cnt <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_mis) r_mis_cnt <= brq_sat_inc(r_mis_cnt);
            if (w_pop) r_res_cnt <= brq_sat_inc(r_res_cnt);
        end
    end

    assign mispredict_count = r_mis_cnt;
    assign resolve_count    = r_res_cnt;
`endif

endmodule

// File: doc/branch_resolution_queue.md
BRANCH_RESOLUTION_QUEUE -- requirements
Module: branch_resolution_queue

Interface
REQ-001 Parameter address_width, default 1: width of branch address; matches the predictor's address_width.
REQ-002 Parameter depth, default 4: in-flight branch entries; power of two, at least 2.
REQ-003 clk  in  1  sole clock; all logic on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 pred_valid  in  1  a predicted branch is issued this cycle.
REQ-006 pred_address  in  address_width  address of the issued branch.
REQ-007 pred_taken  in  1  prediction bit used at issue.
REQ-008 pred_ready  out  1  queue can accept an issue; equals (count != depth).
REQ-009 res_valid  in  1  oldest in-flight branch resolves this cycle; resolutions arrive in order.
REQ-010 res_taken  in  1  actual outcome of the resolving branch.
REQ-011 upd_cs, upd_enable  out  1 each  predictor training strobes, registered.
REQ-012 upd_address  out  address_width  address to train, registered.
REQ-013 upd_result  out  1  outcome to train, registered.
REQ-014 mispredict  out  1  one-cycle pulse: the resolved head was mispredicted.
REQ-015 res_error  out  1  one-cycle pulse: res_valid arrived with the queue empty.

Function
REQ-016 Storage SHALL be a circular buffer of {address, predicted bit}, with head and tail pointers of log2(depth) bits each that wrap modulo depth, and a count of log2(depth)+1 bits.
REQ-017 An issue SHALL write at tail only when pred_valid && pred_ready; when full, the issue SHALL be dropped, even if a pop occurs in the same cycle.
REQ-018 A resolution with count != 0 SHALL pop the head and, one cycle later, assert upd_cs=upd_enable=1 for exactly one cycle with upd_address=head address and upd_result=res_taken.
REQ-019 Update strobes SHALL be 0 in every cycle not following a valid pop; upd_address and upd_result SHALL hold their last values.
REQ-020 If the popped entry's predicted bit != res_taken, mispredict SHALL pulse in the same cycle as the update strobes.
REQ-021 A mispredicting pop SHALL flush all remaining entries (count=0, head=tail) on that edge; an issue in the same cycle SHALL be discarded.
REQ-022 If issue and correct-prediction pop coincide with 0<count<depth, count SHALL be unchanged and both pointers SHALL advance.
REQ-023 If res_valid arrives with count==0, there SHALL be no pop and no update; res_error SHALL pulse next cycle; a same-cycle issue SHALL still be accepted.
REQ-024 Latency SHALL be: issue to poppable, 1 cycle; resolution to update/mispredict, 1 cycle.

Reset
REQ-025 rst_n low SHALL immediately clear head, tail and count; set upd_cs, upd_enable, upd_result, mispredict and res_error to 0; set upd_address to 0; and make pred_ready=1.
REQ-026 Reset mid-operation SHALL discard all in-flight entries; storage contents need not be cleared.
REQ-027 After rst_n rises, the first issue SHALL be accepted on the first rising edge.

Configuration
REQ-028 Macro BRQ_MISPREDICT_STATS_EN, when defined, SHALL add output mispredict_count (16 bits) and output resolve_count (16 bits).
REQ-029 With the macro defined, the counters SHALL be reset to 0, increment on each mispredict pulse and each update strobe respectively, and saturate at 16'hFFFF.
REQ-030 Without the macro, the counters and their ports SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 A shared header SHALL hold the default address_width, default depth and the counter width (16).
REQ-032 Sub-module brq_fifo SHALL hold storage, pointers, count and flush; the top level SHALL hold compare, update registers, pulses and the optional counters.

Verification
REQ-033 With depth=4, issue 4 branches with no resolution -> pred_ready=0 after the 4th; a 5th issue is dropped, and count stays 4.
REQ-034 Issue addr 1 predicted taken, then resolve taken -> next cycle upd_cs=upd_enable=1, upd_address=1, upd_result=1, mispredict=0.
REQ-035 Issue addrs 0,1,0 all predicted taken, then resolve not-taken -> next cycle mispredict=1 and upd_result=0; queue empty and pred_ready=1; a same-cycle issue is absent from the queue.
REQ-036 Assert res_valid on an empty queue -> res_error pulses once and upd_enable stays 0.
REQ-037 Run 10 issue/pop cycles at count=2 -> pointers wrap and entries return in order; with BRQ_MISPREDICT_STATS_EN, resolve_count=10.
REQ-038 Drop rst_n with 3 entries queued, mid-cycle -> outputs clear immediately, and the first post-reset resolution gives res_error=1.
